mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating IF fetches and MEM data accesses
// onto a single 8-bit synchronous RAM port (one-cycle read latency).
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_inst,
  output logic              if_done,
  input  logic              me_req,
  input  logic              me_we,
  input  logic [31:0]       me_addr,
  input  logic [1:0]        me_len,
  input  logic [31:0]       me_wdata,
  output logic [31:0]       me_rdata,
  output logic              me_done,
  output logic              stall_req_from_if,
  output logic              stall_req_from_me,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  // Handshake: a requester holds req high until it sees its one-cycle done
  // pulse; the controller samples req only in IDLE, so a req still high after
  // done starts a fresh transaction.
  typedef enum logic [2:0] {IDLE, IF_RD, ME_RD, ME_WR, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic [2:0]        cnt;
  logic [2:0]        n_q;
  logic              src_me;
  logic [2:0]        me_n;

  always_comb begin
    case (me_len)
      2'b00:   me_n = 3'd1;
      2'b01:   me_n = 3'd2;
      default: me_n = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      cnt     <= '0;
      n_q     <= '0;
      src_me  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt    <= '0;
          data_q <= '0;
          if (me_req) begin
            src_me  <= 1'b1;
            addr_q  <= me_addr[ADDR_W-1:0];
            n_q     <= me_n;
            wdata_q <= me_wdata;
          end else if (if_req) begin
            src_me  <= 1'b0;
            addr_q  <= if_addr[ADDR_W-1:0];
            n_q     <= 3'd4;
            wdata_q <= '0;
          end
        end
        IF_RD, ME_RD: begin
          // mem_din lags mem_a by one cycle, so byte k lands when cnt == k+1
          cnt <= cnt + 3'd1;
          for (int k = 0; k < 4; k++) begin
            if (cnt == 3'(k + 1)) data_q[8*k +: 8] <= mem_din;
          end
        end
        ME_WR: cnt <= cnt + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (me_req)      state_nx = me_we ? ME_WR : ME_RD;
        else if (if_req) state_nx = IF_RD;
      end
      IF_RD, ME_RD: if (cnt == n_q) state_nx = DONE;
      ME_WR:        if (cnt == n_q - 3'd1) state_nx = DONE;
      DONE:         state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if_done  = 1'b0;
    me_done  = 1'b0;
    if_inst  = '0;
    me_rdata = '0;
    case (state)
      IF_RD, ME_RD: begin
        if (cnt < n_q) mem_a = addr_q + ADDR_W'(cnt);
      end
      ME_WR: begin
        mem_a    = addr_q + ADDR_W'(cnt);
        mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
        mem_wr   = 1'b1;
      end
      DONE: begin
        if (src_me) begin
          me_done  = 1'b1;
          me_rdata = data_q;
        end else begin
          if_done = 1'b1;
          if_inst = data_q;
        end
      end
      default: ;
    endcase
  end

  assign stall_req_from_if = if_req & ~if_done;
  assign stall_req_from_me = me_req & ~me_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, scoreboarded done pulses and
// write strobes, plus per-cycle address and stall checks in the drivers.
module tb_mem_ctrl;
  localparam int AW = 17;
  localparam int W  = 66;
  localparam logic [31:0] MASK = 32'h0001_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, me_req, me_we;
  logic [31:0]   if_addr, me_addr, me_wdata;
  logic [1:0]    me_len;
  logic [31:0]   if_inst, me_rdata;
  logic          if_done, me_done;
  logic          stall_req_from_if, stall_req_from_me;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_dout, mem_din;
  logic          mem_wr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {check_data, is_me, data, done_cycle}
  logic [W-1:0] exp_q[$];
  // {cycle, addr, byte}
  logic [63:0]  exp_wr_q[$];
  logic [W-1:0] e;
  logic [63:0]  ew;

  logic [7:0] ram [0:(1<<AW)-1];

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
    .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_len(me_len),
    .me_wdata(me_wdata), .me_rdata(me_rdata), .me_done(me_done),
    .stall_req_from_if(stall_req_from_if), .stall_req_from_me(stall_req_from_me),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  // clock / cycle counter / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: done pulses and write strobes against the expected queues
  always @(negedge clk) begin
    if (if_done === 1'b1 || me_done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("done_src", 64'(me_done), 64'(e[64]));
        chk("done_cycle", 64'(cyc), 64'(e[31:0]));
        if (e[65]) chk("done_data", me_done ? me_rdata : if_inst, 64'(e[63:32]));
      end
    end
    if (mem_wr === 1'b1) begin
      if (exp_wr_q.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        ew = exp_wr_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(ew[63:32]));
        chk("wr_addr", 64'(mem_a), 64'(ew[31:8]));
        chk("wr_byte", 64'(mem_dout), 64'(ew[7:0]));
      end
    end
  end

  task automatic drop_req(input bit is_me);
    if (is_me) me_req = 1'b0;
    else       if_req = 1'b0;
  endtask

  task automatic run_txn(input bit is_me, input bit we, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input bit hold, input bit drop_early);
    int n, t, k, done_cyc;
    bit seen;
    logic [31:0] a;
    n = !is_me ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
    @(negedge clk);
    if (is_me) begin
      me_req = 1'b1; me_we = we; me_addr = addr; me_len = len; me_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    t = cyc;
    done_cyc = t + n + (we ? 1 : 2);
    exp_q.push_back({~we, is_me, exp_data, 32'(done_cyc)});
    if (we) begin
      for (int j = 0; j < n; j++) begin
        a = (addr + 32'(j)) & MASK;
        exp_wr_q.push_back({32'(t + 1 + j), a[23:0], wdata[8*j +: 8]});
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      k = cyc - t - 1;
      if (k >= 0 && k < n) begin
        chk("mem_a", 64'(mem_a), 64'((addr + 32'(k)) & MASK));
        if (!we) chk("mem_wr_on_read", 64'(mem_wr), 0);
      end
      if (is_me ? me_done : if_done) seen = 1'b1;
      else begin
        if (!drop_early)
          chk(is_me ? "stall_me" : "stall_if", is_me ? stall_req_from_me : stall_req_from_if, 1);
        if (drop_early && cyc == t + 2) begin
          drop_req(is_me);
          if_addr = 32'h55; me_addr = 32'h55; me_len = 2'b00; me_wdata = ~wdata;
        end
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    else if (!drop_early)
      chk("stall_at_done", is_me ? stall_req_from_me : stall_req_from_if, 0);
    if (!hold) drop_req(is_me);
  endtask

  initial begin
    int t;
    bit seen;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    {ram[32'h100], ram[32'h101], ram[32'h102], ram[32'h103]} = {8'h13, 8'h05, 8'h00, 8'h00};
    {ram[32'h200], ram[32'h201], ram[32'h202], ram[32'h203]} = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    {ram[32'h1FFFE], ram[32'h1FFFF], ram[0], ram[1]} = {8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; if_req = 0; me_req = 0; me_we = 0; if_addr = 0; me_addr = 0;
    me_len = 0; me_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_a", 64'(mem_a), 0);
    chk("rst_mem_wr", 64'(mem_wr), 0);
    chk("rst_if_done", 64'(if_done), 0);
    chk("rst_me_done", 64'(me_done), 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_me_rdata", me_rdata, 0);
    rst = 1'b0;

    run_txn(0, 0, 32'h100, 2'b10, 0, 32'h0000_0513, 0, 0);        // fetch
    run_txn(1, 1, 32'h10, 2'b01, 32'hAABB_CCDD, 0, 0, 0);         // half write
    run_txn(1, 0, 32'h10, 2'b01, 0, 32'h0000_CCDD, 0, 0);         // half read back
    run_txn(1, 0, 32'h11, 2'b00, 0, 32'h0000_00CC, 0, 0);         // byte read
    run_txn(1, 0, 32'h100, 2'b11, 0, 32'h0000_0513, 0, 0);        // len 11 = word
    run_txn(1, 0, 32'h1FFFE, 2'b10, 0, 32'h4433_2211, 0, 0);      // address wrap
    run_txn(0, 0, 32'h200, 2'b10, 0, 32'hEFBE_ADDE, 0, 1);        // req dropped mid-way

    // simultaneous requests: MEM wins, IF follows after the next IDLE
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    me_req = 1; me_we = 0; me_addr = 32'h200; me_len = 2'b10;
    t = cyc;
    exp_q.push_back({1'b1, 1'b1, 32'hEFBE_ADDE, 32'(t + 6)});
    exp_q.push_back({1'b1, 1'b0, 32'h0000_0513, 32'(t + 13)});
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (me_done) me_req = 1'b0;
      if (if_done) seen = 1'b1;
      else chk("stall_if_pending", 64'(stall_req_from_if), 1);
    end
    if (!seen) chk("both_timeout", 0, 1);
    if_req = 1'b0;

    // request held after done: back-to-back fetches
    run_txn(0, 0, 32'h100, 2'b10, 0, 32'h0000_0513, 1, 0);
    run_txn(0, 0, 32'h100, 2'b10, 0, 32'h0000_0513, 0, 0);

    // reset during a word write, after the second byte
    @(negedge clk);
    me_req = 1; me_we = 1; me_addr = 32'h40; me_len = 2'b10; me_wdata = 32'h1122_3344;
    t = cyc;
    exp_wr_q.push_back({32'(t + 1), 24'h40, 8'h44});
    exp_wr_q.push_back({32'(t + 2), 24'h41, 8'h33});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("stall_me_in_rst", 64'(stall_req_from_me), 1);
    @(negedge clk);
    chk("rst_abort_wr", 64'(mem_wr), 0);
    chk("rst_abort_a", 64'(mem_a), 0);
    rst = 1'b0; me_req = 1'b0; me_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_wr", 64'(mem_wr), 0);
      chk("post_rst_done", 64'(me_done), 0);
    end
    chk("ram_41", 64'(ram[32'h41]), 64'h33);
    chk("ram_42", 64'(ram[32'h42]), 0);
    chk("ram_11", 64'(ram[32'h11]), 64'hCC);
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    chk("exp_wr_q_empty", 64'(exp_wr_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
